multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_W, default 3: opcode width; SHALL be at least 3.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 op  in  OP_W  opcode field of the memory read data; sampled only on instruction fetch.
REQ-006 mem_ready  in  1  memory handshake; the access completes in a cycle where mem_ready=1.
REQ-007 Outputs, 1 bit each: mem_read, mem_write, iord (0=PC address, 1=ALU address), ir_write, pc_write, pc_write_cond, reg_write, alu_src_a (0=PC, 1=rs), illegal_op.
REQ-008 Outputs, 2 bits each: reg_dst (00 rt, 01 rd, 10 r7), mem_to_reg (00 ALU, 01 mem, 10 PC), alu_op (00 funct, 01 sub, 10 slt, 11 add), alu_src_b (00 rt, 01 const 2, 10 imm, 11 imm<<1), pc_src (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 retired  out  CNT_W  count of completed legal instructions.

Function
REQ-010 The block SHALL be a Moore FSM; every output SHALL be a function of the state register and op_q only.
REQ-011 op_q SHALL capture op in a FETCH cycle with mem_ready=1, and hold it otherwise.
REQ-012 Opcode map (low 3 bits, upper bits zero): 000 R, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi; any nonzero upper bit SHALL be illegal.
REQ-013 IDLE: all outputs 0; next state FETCH.
REQ-014 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=11, pc_src=00; ir_write=pc_write=mem_ready; the FSM stays in FETCH while mem_ready=0.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=11; next state by op: R, slti, addi -> EXEC; lw, sw -> ADDR; beq -> BRANCH; j -> JUMP; jal -> JAL; illegal -> TRAP.
REQ-016 EXEC: alu_src_a=1; R: alu_src_b=00, alu_op=00; slti: alu_src_b=10, alu_op=10; addi: alu_src_b=10, alu_op=11; next state ALU_WB.
REQ-017 ALU_WB: reg_write=1, mem_to_reg=00, reg_dst=01 for R and 00 otherwise; next state FETCH.
REQ-018 ADDR: alu_src_a=1, alu_src_b=10, alu_op=11; next state MEM_RD for lw, MEM_WR for sw.
REQ-019 MEM_RD: mem_read=1, iord=1; the FSM stays while mem_ready=0, then goes to LOAD_WB.
REQ-020 LOAD_WB: reg_write=1, reg_dst=00, mem_to_reg=01; next state FETCH.
REQ-021 MEM_WR: mem_write=1, iord=1; the FSM stays while mem_ready=0, then goes to FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; next state FETCH.
REQ-023 JUMP: pc_write=1, pc_src=10; next state FETCH.
REQ-024 JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; next state FETCH.
REQ-025 TRAP: illegal_op=1 for exactly one cycle with no writes; next state FETCH.
REQ-026 Unlisted outputs SHALL be 0 in every state.
REQ-027 Latency in cycles, with zero memory wait: R/slti/addi 4; lw 5; sw 4; beq, j, jal 3; illegal 3.
REQ-028 Each memory wait cycle SHALL add exactly one cycle, with outputs held constant.
REQ-029 retired SHALL increment by 1 on exit from ALU_WB, LOAD_WB, BRANCH, JUMP or JAL, and on completion of MEM_WR; it SHALL NOT increment from TRAP.
REQ-030 retired SHALL wrap modulo 2^CNT_W.
REQ-031 The state register SHALL return to IDLE from any encoding outside the defined states.

Reset
REQ-032 While rst_n=0, the block SHALL hold state=IDLE, op_q=0 and retired=0, and drive all outputs to 0, independent of clk.
REQ-033 Reset asserted mid-instruction (including during a memory wait) SHALL abandon the instruction without a write or a retire.
REQ-034 The first cycle after reset release SHALL be IDLE, and the second SHALL be FETCH.

Structure
REQ-035 A shared package multicycle_pkg SHALL hold: the state enum, the opcode constants, and the encodings for alu_op, alu_src_b, pc_src, reg_dst and mem_to_reg.
REQ-036 Output decoding SHALL sit in one combinational sub-module, mc_output_decode (inputs state and op_q); multicycle_control keeps the state register, op_q and the counter.

Verification
REQ-037 Reset release, mem_ready=1, op=000 -> states IDLE, FETCH, DECODE, EXEC, ALU_WB; reg_write=1 and reg_dst=01 in the fifth cycle; retired=1.
REQ-038 op=100 with mem_ready low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles with mem_read=1 and iord=1 throughout; LOAD_WB follows with mem_to_reg=01.
REQ-039 op=011 -> JAL cycle has pc_write=1, pc_src=10, reg_dst=10, mem_to_reg=10 and reg_write=1.
REQ-040 OP_W=4, op=1010 -> TRAP with illegal_op high for exactly 1 cycle, no write strobe, and retired unchanged.
REQ-041 rst_n driven low mid-cycle during MEM_WR -> mem_write drops to 0 immediately; after release, IDLE then FETCH, and retired=0.
REQ-042 CNT_W=2, five legal instructions -> retired reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle control FSM.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_ALU_WB  = 4'd4,
        S_ADDR    = 4'd5,
        S_MEM_RD  = 4'd6,
        S_LOAD_WB = 4'd7,
        S_MEM_WR  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_JAL     = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    // Opcodes live in the low 3 bits; any set upper bit is illegal.
    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_SLTI = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam logic [1:0] ALU_FUNCT = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_SLT   = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_R7 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: control word from current state and latched opcode.
module mc_output_decode
    import multicycle_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  state_t          state,
    input  logic [OP_W-1:0] op_q,
    output logic            mem_read,
    output logic            mem_write,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic            illegal_op,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic [1:0]      alu_op,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src
);

    logic is_r;
    logic is_slti;

    assign is_r    = (op_q == OP_W'(OP_R));
    assign is_slti = (op_q == OP_W'(OP_SLTI));

    // Everything defaults to 0; each state raises only its own controls.
    // In FETCH ir_write/pc_write are raised unconditionally and the top
    // qualifies them with mem_ready.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        illegal_op    = 1'b0;
        reg_dst       = RDST_RT;
        mem_to_reg    = M2R_ALU;
        alu_op        = ALU_FUNCT;
        alu_src_b     = SRCB_RT;
        pc_src        = PC_ALU;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_TWO;
                alu_op    = ALU_ADD;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (is_r) begin
                    alu_src_b = SRCB_RT;
                    alu_op    = ALU_FUNCT;
                end else if (is_slti) begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_SLT;
                end else begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                end
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = is_r ? RDST_RD : RDST_RT;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_ALUOUT;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = PC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = RDST_R7;
                mem_to_reg = M2R_PC;
            end
            S_TRAP: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control: state register, latched opcode, retire counter.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             illegal_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [CNT_W-1:0] retired
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire;
    logic              dec_ir_write;
    logic              dec_pc_write;

    // Next state, opcode capture and retire detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op_q)
                    OP_W'(OP_R), OP_W'(OP_SLTI), OP_W'(OP_ADDI): state_d = S_EXEC;
                    OP_W'(OP_LW), OP_W'(OP_SW):                  state_d = S_ADDR;
                    OP_W'(OP_BEQ):                               state_d = S_BRANCH;
                    OP_W'(OP_J):                                 state_d = S_JUMP;
                    OP_W'(OP_JAL):                               state_d = S_JAL;
                    default:                                     state_d = S_TRAP;
                endcase
            end
            S_EXEC:    state_d = S_ALU_WB;
            S_ADDR:    state_d = (op_q == OP_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) state_d = S_LOAD_WB;
            S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
            S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JUMP, S_JAL, S_TRAP:
                       state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase

        op_d = (state_q == S_FETCH && mem_ready) ? op : op_q;

        // TRAP deliberately does not retire.
        retire = (state_q == S_ALU_WB) || (state_q == S_LOAD_WB) ||
                 (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                 (state_q == S_JAL) || (state_q == S_MEM_WR && mem_ready);
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // State, opcode and counter registers; reset forces IDLE so every output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    mc_output_decode #(.OP_W(OP_W)) u_dec (
        .state         (state_q),
        .op_q          (op_q),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (dec_ir_write),
        .pc_write      (dec_pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .illegal_op    (illegal_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src)
    );

    // The fetch strobes fire only on the cycle the instruction word arrives.
    assign ir_write = dec_ir_write & mem_ready;
    assign pc_write = dec_pc_write & (mem_ready | (state_q != S_FETCH));
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model plus directed pins.
module tb_multicycle_control;

    localparam int OP_W  = 4;
    localparam int CNT_W = 2;

    // Bit positions within the packed 19-bit control word.
    localparam int B_MRD = 18, B_MWR = 17, B_IORD = 16, B_IRW = 15, B_PCW = 14;
    localparam int B_PCC = 13, B_RW = 12, B_ILL = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [OP_W-1:0]  op;
    logic             mem_ready;
    logic             mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic             reg_write, alu_src_a, illegal_op;
    logic [1:0]       reg_dst, mem_to_reg, alu_op, alu_src_b, pc_src;
    logic [CNT_W-1:0] retired;
    logic [18:0]      dut_vec;

    multicycle_control #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .illegal_op(illegal_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .retired(retired)
    );

    assign dut_vec = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                      reg_write, alu_src_a, illegal_op, reg_dst, mem_to_reg,
                      alu_op, alu_src_b, pc_src};

    always #5 clk = ~clk;

    // Model: a queue of the cycle phases still to run for the current instruction.
    typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXEC_R, P_EXEC_SLTI, P_EXEC_ADDI,
                  P_WB_R, P_WB_I, P_ADDR, P_MEM_RD, P_LOAD_WB, P_MEM_WR,
                  P_BRANCH, P_JUMP, P_JAL, P_TRAP} phase_t;

    phase_t      q[$];
    int          retired_m;
    int          done_cnt;
    int          n_pass, n_total;
    logic [18:0] last_obs;
    int          mrd_cnt, ill_cnt;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic logic [18:0] exp_vec(input phase_t p, input logic mr);
        logic mrd, mwr, io, irw, pcw, pcc, rw, asa, ill;
        logic [1:0] rd, m2r, aop, asb, psrc;
        {mrd, mwr, io, irw, pcw, pcc, rw, asa, ill} = '0;
        {rd, m2r, aop, asb, psrc} = '0;
        case (p)
            P_FETCH:     begin mrd = 1; asb = 2'b01; aop = 2'b11; irw = mr; pcw = mr; end
            P_DECODE:    begin asb = 2'b11; aop = 2'b11; end
            P_EXEC_R:    begin asa = 1; asb = 2'b00; aop = 2'b00; end
            P_EXEC_SLTI: begin asa = 1; asb = 2'b10; aop = 2'b10; end
            P_EXEC_ADDI: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            P_WB_R:      begin rw = 1; rd = 2'b01; end
            P_WB_I:      begin rw = 1; end
            P_ADDR:      begin asa = 1; asb = 2'b10; aop = 2'b11; end
            P_MEM_RD:    begin mrd = 1; io = 1; end
            P_LOAD_WB:   begin rw = 1; m2r = 2'b01; end
            P_MEM_WR:    begin mwr = 1; io = 1; end
            P_BRANCH:    begin asa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
            P_JUMP:      begin pcw = 1; psrc = 2'b10; end
            P_JAL:       begin pcw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
            P_TRAP:      ill = 1;
            default: ;
        endcase
        return {mrd, mwr, io, irw, pcw, pcc, rw, asa, ill, rd, m2r, aop, asb, psrc};
    endfunction

    function automatic bit is_wait(input phase_t p);
        return p == P_FETCH || p == P_MEM_RD || p == P_MEM_WR;
    endfunction

    function automatic bit retires(input phase_t p);
        return p inside {P_WB_R, P_WB_I, P_LOAD_WB, P_MEM_WR, P_BRANCH, P_JUMP, P_JAL};
    endfunction

    task automatic push_instr(input logic [OP_W-1:0] o);
        q.push_back(P_DECODE);
        if (o[3]) q.push_back(P_TRAP);
        else case (o[2:0])
            3'd0: begin q.push_back(P_EXEC_R);    q.push_back(P_WB_R); end
            3'd1: begin q.push_back(P_EXEC_SLTI); q.push_back(P_WB_I); end
            3'd7: begin q.push_back(P_EXEC_ADDI); q.push_back(P_WB_I); end
            3'd4: begin q.push_back(P_ADDR); q.push_back(P_MEM_RD); q.push_back(P_LOAD_WB); end
            3'd5: begin q.push_back(P_ADDR); q.push_back(P_MEM_WR); end
            3'd6: q.push_back(P_BRANCH);
            3'd2: q.push_back(P_JUMP);
            default: q.push_back(P_JAL);
        endcase
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back(P_IDLE);
        retired_m = 0;
    endtask

    // One clock cycle: entered just after a rising edge; compare at the falling edge.
    task automatic cycle(input logic [OP_W-1:0] op_v, input logic mr_v);
        phase_t h;
        op = op_v;
        mem_ready = mr_v;
        @(negedge clk);
        chk($sformatf("outs@%s", q[0].name()), 32'(dut_vec), 32'(exp_vec(q[0], mr_v)));
        chk("retired", 32'(retired), 32'(retired_m));
        last_obs = dut_vec;
        if (dut_vec[B_MRD] && dut_vec[B_IORD]) mrd_cnt++;
        if (dut_vec[B_ILL]) ill_cnt++;
        @(posedge clk);
        h = q[0];
        if (!(is_wait(h) && !mr_v)) begin
            h = q.pop_front();
            if (retires(h)) begin
                retired_m = (retired_m + 1) % (1 << CNT_W);
                done_cnt++;
            end
            if (h == P_TRAP) done_cnt++;
            if (h == P_FETCH) push_instr(op_v);
            if (q.size() == 0) q.push_back(P_FETCH);
        end
        #1;
    endtask

    // Run until the model sees one instruction finish; nwait stalls on the data access.
    task automatic run_instr(input logic [OP_W-1:0] op_v, input int nwait, output int ncyc);
        int start, waited;
        logic mr;
        logic [OP_W-1:0] o;
        start = done_cnt; waited = 0; ncyc = 0; mrd_cnt = 0; ill_cnt = 0;
        while (done_cnt == start && ncyc < 60) begin
            mr = 1'b1;
            if ((q[0] == P_MEM_RD || q[0] == P_MEM_WR) && waited < nwait) begin
                mr = 1'b0;
                waited++;
            end
            o = (q[0] == P_FETCH) ? op_v : OP_W'($urandom_range(0, 15));
            cycle(o, mr);
            ncyc++;
        end
        chk("instr_done", 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        int n;
        logic [4:0] wmask;
        n_pass = 0; n_total = 0; done_cnt = 0;
        op = '0; mem_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outs", 32'(dut_vec), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("reset_hold", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // R-type from reset: IDLE FETCH DECODE EXEC ALU_WB.
        run_instr(4'b0000, 0, n);
        chk("r_cycles", 32'(n), 32'd5);
        chk("r_wb_fields", 32'({last_obs[B_RW], last_obs[9:8]}), 32'b1_01);
        chk("ret_seq_1", 32'(retired), 32'd1);

        // lw with three wait cycles in MEM_RD.
        run_instr(4'b0100, 3, n);
        chk("lw_cycles", 32'(n), 32'd8);
        chk("lw_memrd_cycles", 32'(mrd_cnt), 32'd4);
        chk("lw_wb_m2r", 32'(last_obs[7:6]), 32'b01);
        chk("ret_seq_2", 32'(retired), 32'd2);

        // jal.
        run_instr(4'b0011, 0, n);
        chk("jal_cycles", 32'(n), 32'd3);
        chk("jal_fields", 32'({last_obs[B_PCW], last_obs[B_RW], last_obs[9:8],
                               last_obs[7:6], last_obs[1:0]}), 32'b1_1_10_10_10);
        chk("ret_seq_3", 32'(retired), 32'd3);

        // Illegal opcode with an upper bit set.
        run_instr(4'b1010, 0, n);
        chk("trap_cycles", 32'(n), 32'd3);
        chk("trap_ill_cnt", 32'(ill_cnt), 32'd1);
        wmask = {last_obs[B_MWR], last_obs[B_IRW], last_obs[B_PCW], last_obs[B_PCC], last_obs[B_RW]};
        chk("trap_no_write", 32'(wmask), 32'd0);
        chk("trap_retired", 32'(retired), 32'd3);

        // sw then beq: counter wraps 3 -> 0 -> 1.
        run_instr(4'b0101, 0, n);
        chk("sw_cycles", 32'(n), 32'd4);
        chk("ret_seq_4", 32'(retired), 32'd0);
        run_instr(4'b0110, 0, n);
        chk("beq_cycles", 32'(n), 32'd3);
        chk("ret_seq_5", 32'(retired), 32'd1);

        // Reset asserted between edges while MEM_WR is stalled.
        n = 0;
        while (q[0] != P_MEM_WR && n < 10) begin
            cycle(4'b0101, 1'b1);
            n++;
        end
        mem_ready = 1'b0;
        #2;
        chk("memwr_before_rst", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(dut_vec), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(4'b0000, 1'b1);
        chk("post_rst_idle", 32'(last_obs), 32'd0);
        cycle(4'b0000, 1'b1);
        chk("post_rst_fetch_mrd", 32'(last_obs[B_MRD]), 32'd1);

        // Random opcodes and memory handshakes against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [OP_W-1:0] o;
            o = ($urandom_range(0, 3) == 0) ? OP_W'($urandom_range(8, 15))
                                            : OP_W'($urandom_range(0, 7));
            cycle(o, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
